// File: rtl/dram_read_arbiter_if.sv
// Signal bundle for the two-requester DRAM read arbiter: requester ports plus
// the read-engine command and data-return path.
interface dram_read_arbiter_if;
    logic        p0_kick, p1_kick;
    logic [31:0] p0_num, p1_num;
    logic [31:0] p0_addr, p1_addr;
    logic        p0_busy, p1_busy;
    logic        p0_done, p1_done;
    logic        p0_we, p1_we;
    logic [31:0] dout;
    logic        grant;
    logic        err;
    logic        m_kick;
    logic [31:0] m_num, m_addr;
    logic        m_busy;
    logic        m_we;
    logic [31:0] m_dout;

    // slave: the arbiter's view
    modport slave (
        input  p0_kick, p1_kick, p0_num, p1_num, p0_addr, p1_addr,
               m_busy, m_we, m_dout,
        output p0_busy, p1_busy, p0_done, p1_done, p0_we, p1_we,
               dout, grant, err, m_kick, m_num, m_addr
    );

    // master: the surrounding requesters and read engine
    modport master (
        output p0_kick, p1_kick, p0_num, p1_num, p0_addr, p1_addr,
               m_busy, m_we, m_dout,
        input  p0_busy, p1_busy, p0_done, p1_done, p0_we, p1_we,
               dout, grant, err, m_kick, m_num, m_addr
    );
endinterface

// File: rtl/dram_read_arbiter.sv
// Two-port round-robin arbiter in front of a single DRAM read engine: captures
// requests, issues one engine command at a time and steers returned words.
module dram_read_arbiter #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    dram_read_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, RUN, DONE} state_t;

    state_t           state;
    logic [1:0]       pending;
    logic [1:0][31:0] req_num, req_addr;
    logic             last;
    logic [31:0]      wait_cnt;
    logic [31:0]      word_cnt;
    logic [1:0]       kick;
    logic [1:0][31:0] num_in, addr_in;
    logic             sel;
    logic             xfer;

    assign kick        = {bus.p1_kick, bus.p0_kick};
    assign num_in      = {bus.p1_num, bus.p0_num};
    assign addr_in     = {bus.p1_addr, bus.p0_addr};
    assign bus.p0_busy = pending[0];
    assign bus.p1_busy = pending[1];
    // With both pending, favour the port that was not served last.
    assign sel         = (&pending) ? ~last : pending[1];
    assign xfer        = (state == WAIT_BUSY) || (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= '0;
            req_num     <= '0;
            req_addr    <= '0;
            last        <= 1'b1;
            wait_cnt    <= '0;
            word_cnt    <= '0;
            bus.m_kick  <= 1'b0;
            bus.m_num   <= '0;
            bus.m_addr  <= '0;
            bus.p0_done <= 1'b0;
            bus.p1_done <= 1'b0;
            bus.p0_we   <= 1'b0;
            bus.p1_we   <= 1'b0;
            bus.dout    <= '0;
            bus.grant   <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            bus.m_kick  <= 1'b0;
            bus.p0_done <= 1'b0;
            bus.p1_done <= 1'b0;
            bus.p0_we   <= 1'b0;
            bus.p1_we   <= 1'b0;
            bus.err     <= 1'b0;

            for (int i = 0; i < 2; i++) begin
                if (kick[i] && !pending[i]) begin
                    pending[i]  <= 1'b1;
                    req_num[i]  <= num_in[i];
                    req_addr[i] <= addr_in[i];
                end
            end

            // Words outside a transfer or beyond the requested count are dropped.
            if (bus.m_we) begin
                if (xfer)
                    word_cnt <= word_cnt + 32'd1;
                if (xfer && (word_cnt < bus.m_num)) begin
                    bus.dout <= bus.m_dout;
                    if (bus.grant) bus.p1_we <= 1'b1;
                    else           bus.p0_we <= 1'b1;
                end else begin
                    bus.err <= 1'b1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (pending != 2'b00) begin
                        bus.grant  <= sel;
                        bus.m_num  <= req_num[sel];
                        bus.m_addr <= req_addr[sel];
                        if (req_num[sel] == 32'd0) begin
                            state <= DONE;
                        end else begin
                            state      <= ISSUE;
                            bus.m_kick <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.m_busy) begin
                        state <= RUN;
                    end else if (wait_cnt == 32'(TIMEOUT - 1)) begin
                        bus.err <= 1'b1;
                        state   <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                RUN: begin
                    if (!bus.m_busy && (word_cnt >= bus.m_num))
                        state <= DONE;
                end
                DONE: begin
                    if (bus.grant) bus.p1_done <= 1'b1;
                    else           bus.p0_done <= 1'b1;
                    pending[bus.grant] <= 1'b0;
                    last               <= bus.grant;
                    word_cnt           <= '0;
                    state              <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dram_read_arbiter.sv
// Directed bench for dram_read_arbiter: a table of single-request transfers
// against a simple read-engine model, plus hand-written multi-request sequences.
module tb_dram_read_arbiter;
    localparam int TIMEOUT = 1023;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dram_read_arbiter_if bus();
    dram_read_arbiter #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        bit          port;
        logic [31:0] num;
        logic [31:0] addr;
        int          delay;
        int          extra;
        bit          mute;
        int          exp_words;
        int          exp_err;
        int          exp_kick;
        int          min_cyc;
        int          max_cyc;
    } vec_t;

    int n_chk = 0, n_pass = 0;
    int eng_delay = 1, eng_extra = 0;
    bit eng_mute = 1'b0;

    logic [31:0] q0[$], q1[$], gq[$], aq[$], nq[$];
    int d0, d1, n_err, n_kick, viol;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [127:0] outs();
        return 128'({bus.m_kick, bus.m_num, bus.m_addr, bus.p0_busy, bus.p1_busy,
                     bus.p0_done, bus.p1_done, bus.p0_we, bus.p1_we, bus.dout,
                     bus.grant, bus.err});
    endfunction

    always @(negedge clk) begin
        if (bus.p0_we) q0.push_back(bus.dout);
        if (bus.p1_we) q1.push_back(bus.dout);
        if (bus.p0_done) d0++;
        if (bus.p1_done) d1++;
        if (bus.err) n_err++;
        if (bus.m_kick) begin
            n_kick++;
            gq.push_back(32'(bus.grant));
            aq.push_back(bus.m_addr);
            nq.push_back(bus.m_num);
        end
        if (((bus.p0_we | bus.p0_done) && bus.grant !== 1'b0) ||
            ((bus.p1_we | bus.p1_done) && bus.grant !== 1'b1))
            viol++;
    end

    // Read engine: busy eng_delay edges after the kick, then back-to-back words
    // whose data is the command address plus 4 per word.
    initial begin
        int          n;
        logic [31:0] a;
        bus.m_busy = 1'b0;
        bus.m_we   = 1'b0;
        bus.m_dout = '0;
        forever begin
            @(negedge clk);
            if (bus.m_kick && !eng_mute) begin
                n = int'(bus.m_num) + eng_extra;
                a = bus.m_addr;
                repeat (eng_delay) @(posedge clk);
                #1 bus.m_busy = 1'b1;
                for (int i = 0; i < n; i++) begin
                    bus.m_we   = 1'b1;
                    bus.m_dout = a + 32'(4 * i);
                    @(posedge clk);
                    #1;
                end
                bus.m_we   = 1'b0;
                bus.m_busy = 1'b0;
            end
        end
    end

    task automatic clear_mon();
        q0.delete(); q1.delete(); gq.delete(); aq.delete(); nq.delete();
        d0 = 0; d1 = 0; n_err = 0; n_kick = 0; viol = 0;
    endtask

    task automatic kick(input bit port, input logic [31:0] num, input logic [31:0] addr);
        if (port) begin bus.p1_kick = 1'b1; bus.p1_num = num; bus.p1_addr = addr; end
        else      begin bus.p0_kick = 1'b1; bus.p0_num = num; bus.p0_addr = addr; end
        @(negedge clk);
        bus.p0_kick = 1'b0;
        bus.p1_kick = 1'b0;
    endtask

    task automatic wait_done(input bit port, input int maxc, output int cyc);
        cyc = 0;
        while (((port ? bus.p1_done : bus.p0_done) !== 1'b1) && cyc < maxc) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= maxc) begin
            n_chk++;
            $display("FAIL wait_done: port %0d gave no done within %0d cycles", port, maxc);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        clear_mon();
        eng_delay = v.delay;
        eng_extra = v.extra;
        eng_mute  = v.mute;
        kick(v.port, v.num, v.addr);
        wait_done(v.port, 3000, cyc);
        repeat (4) @(negedge clk);
        eng_mute = 1'b0;
        chk({tag, ".kicks"}, 128'(n_kick), 128'(v.exp_kick));
        if (v.exp_kick != 0) begin
            chk({tag, ".m_num"}, 128'(qat(nq, 0)), 128'(v.num));
            chk({tag, ".m_addr"}, 128'(qat(aq, 0)), 128'(v.addr));
        end
        chk({tag, ".words"}, 128'(v.port ? q1.size() : q0.size()), 128'(v.exp_words));
        chk({tag, ".other_words"}, 128'(v.port ? q0.size() : q1.size()), 128'(0));
        for (int i = 0; i < v.exp_words; i++)
            chk($sformatf("%s.data%0d", tag, i), 128'(qat(v.port ? q1 : q0, i)),
                128'(v.addr + 32'(4 * i)));
        chk({tag, ".done"}, 128'(v.port ? d1 : d0), 128'(1));
        chk({tag, ".other_done"}, 128'(v.port ? d0 : d1), 128'(0));
        chk({tag, ".err"}, 128'(n_err), 128'(v.exp_err));
        chk({tag, ".busy_after"}, 128'({bus.p1_busy, bus.p0_busy}), 128'(0));
        chk({tag, ".latency"}, 128'(cyc >= v.min_cyc && cyc <= v.max_cyc), 128'(1));
        chk({tag, ".steer"}, 128'(viol), 128'(0));
    endtask

    vec_t tbl[6];
    vec_t fresh;

    initial begin
        int cyc, nwe;
        bus.p0_kick = 1'b0; bus.p1_kick = 1'b0;
        bus.p0_num  = '0;   bus.p1_num  = '0;
        bus.p0_addr = '0;   bus.p1_addr = '0;

        //            port num    addr          dly ext mute wds err kck min max
        tbl[0] = '{1'b0, 32'd4, 32'h0000_0100, 3, 0, 1'b0, 4, 0, 1, 1, 200};
        tbl[1] = '{1'b1, 32'd1, 32'h0000_2000, 1, 0, 1'b0, 1, 0, 1, 1, 200};
        tbl[2] = '{1'b1, 32'd0, 32'h0000_0040, 1, 0, 1'b0, 0, 0, 0, 1, 3};
        tbl[3] = '{1'b0, 32'd4, 32'h0000_3000, 2, 1, 1'b0, 4, 1, 1, 1, 200};
        tbl[4] = '{1'b1, 32'd3, 32'h4000_0000, 1, 0, 1'b0, 3, 0, 1, 1, 200};
        tbl[5] = '{1'b0, 32'd2, 32'h0000_0500, 1, 0, 1'b1, 0, 1, 1, TIMEOUT + 1, TIMEOUT + 5};

        clear_mon();
        repeat (2) @(negedge clk);
        chk("reset.outs", outs(), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // Same-cycle kicks straight out of reset: port 0 goes first.
        clear_mon();
        bus.p0_kick = 1'b1; bus.p0_num = 32'd2; bus.p0_addr = 32'h300;
        bus.p1_kick = 1'b1; bus.p1_num = 32'd2; bus.p1_addr = 32'h400;
        @(negedge clk);
        bus.p0_kick = 1'b0; bus.p1_kick = 1'b0;
        wait_done(1'b0, 500, cyc);
        wait_done(1'b1, 500, cyc);
        repeat (4) @(negedge clk);
        chk("cont.kicks", 128'(n_kick), 128'(2));
        chk("cont.grant0", 128'(qat(gq, 0)), 128'(0));
        chk("cont.grant1", 128'(qat(gq, 1)), 128'(1));
        chk("cont.q0", 128'({qat(q0, 0), qat(q0, 1)}), 128'({32'h300, 32'h304}));
        chk("cont.q1", 128'({qat(q1, 0), qat(q1, 1)}), 128'({32'h400, 32'h404}));
        chk("cont.dones", 128'({d0, d1}), 128'({32'd1, 32'd1}));
        chk("cont.steer", 128'(viol), 128'(0));

        for (int i = 0; i < 6; i++)
            run_vec(tbl[i], $sformatf("vec%0d", i));

        // Port 1 waits while port 0 re-kicks right after its done: port 1 next.
        clear_mon();
        eng_delay = 1; eng_extra = 0;
        kick(1'b0, 32'd2, 32'h600);
        kick(1'b1, 32'd1, 32'h680);
        wait_done(1'b0, 500, cyc);
        kick(1'b0, 32'd3, 32'h700);
        wait_done(1'b1, 500, cyc);
        wait_done(1'b0, 500, cyc);
        repeat (4) @(negedge clk);
        chk("fair.grants", 128'({qat(gq, 0), qat(gq, 1), qat(gq, 2)}), 128'({32'd0, 32'd1, 32'd0}));
        chk("fair.addr2", 128'(qat(aq, 2)), 128'(32'h700));
        chk("fair.q0n", 128'(q0.size()), 128'(5));
        chk("fair.q0_2", 128'(qat(q0, 2)), 128'(32'h700));
        chk("fair.q1", 128'(qat(q1, 0)), 128'(32'h680));
        chk("fair.steer", 128'(viol), 128'(0));

        // Same-cycle kicks after port 0 was last served: port 1 wins.
        clear_mon();
        bus.p0_kick = 1'b1; bus.p0_num = 32'd1; bus.p0_addr = 32'h800;
        bus.p1_kick = 1'b1; bus.p1_num = 32'd1; bus.p1_addr = 32'h900;
        @(negedge clk);
        bus.p0_kick = 1'b0; bus.p1_kick = 1'b0;
        wait_done(1'b1, 500, cyc);
        wait_done(1'b0, 500, cyc);
        repeat (4) @(negedge clk);
        chk("cont2.grants", 128'({qat(gq, 0), qat(gq, 1)}), 128'({32'd1, 32'd0}));
        chk("cont2.data", 128'({qat(q1, 0), qat(q0, 0)}), 128'({32'h900, 32'h800}));

        // Reset after two of four words; the trailing word lands after reset.
        clear_mon();
        eng_delay = 1;
        kick(1'b0, 32'd4, 32'hA00);
        nwe = 0; cyc = 0;
        while (nwe < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.p0_we) nwe++;
        end
        if (nwe < 2) begin
            n_chk++;
            $display("FAIL rstmid.words: saw %0d words before bound, wanted 2", nwe);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid.outs", outs(), 128'(0));
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rstmid.no_done", 128'(d0 + d1), 128'(0));
        chk("rstmid.late_err", 128'(n_err), 128'(1));
        chk("rstmid.words", 128'(q0.size()), 128'(2));

        fresh = '{1'b0, 32'd4, 32'h0000_0B00, 3, 0, 1'b0, 4, 0, 1, 1, 200};
        run_vec(fresh, "fresh");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
